axi_lite_regfile: RTL and testbench
===================================

# axi_lite_regfile

AXI4-Lite slave register bank sitting directly downstream of `axi_lite_interconnect`, one instance per slave port. It terminates write and read transactions routed by the interconnect, holds `NUM_REGS` 32-bit registers with byte-strobe writes, and returns OKAY or SLVERR responses. Write and read channels run as independent state machines, each with at most one transaction outstanding.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of register 0; must be 4-byte aligned
- `NUM_REGS`, 16, number of 32-bit registers (1..256)
- `RESET_VALUE`, 32'h0, reset contents of every register
- `aclk`  in  1  clock; all logic on the rising edge
- `areset_n`  in  1  asynchronous, active-low reset
- `awaddr`/`awvalid`  in  32/1  write address channel; `awready` out 1
- `wdata`/`wstrb`/`wvalid`  in  32/4/1  write data channel; `wready` out 1
- `bresp` out 2, `bvalid` out 1, `bready` in 1  write response channel
- `araddr`/`arvalid`  in  32/1  read address channel; `arready` out 1
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1  read data channel

## Operation
- Decode: `offset = addr - BASE_ADDR`. In range iff `addr >= BASE_ADDR` and `offset < NUM_REGS*4`. Index is `offset[9:2]`. `addr[1:0]` is ignored.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: `awready`=`wready`=1.
  - AW and W both accepted in the same cycle → W_RESP.
  - AW accepted alone → W_HAVE_ADDR: `awready`=0, `wready`=1.
  - W accepted alone → W_HAVE_DATA: `wready`=0, `awready`=1.
  - Completing the missing handshake → W_RESP.
  - Register update happens on the edge entering W_RESP: byte `i` is written iff `wstrb[i]`=1.
  - W_RESP: `bvalid`=1, both readies 0. Stays there until `bready`, then → W_IDLE.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: `arready`=1. On AR handshake, capture `rdata` and `rresp` → R_RESP.
  - R_RESP: `rvalid`=1, `arready`=0. Stays there until `rready`, then → R_IDLE.
- `rdata`/`rresp`/`bresp` stay stable while their valid is high and waiting for ready.
- Out-of-range access: writes are dropped, reads return 0. Response code is set by the Configuration section.
- Wstrb of 4'b0000 in range: no register changes, response OKAY.

## Timing
- Reset values: `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0; `bresp`, `rresp` = 2'b00; `rdata` = 0; all registers = `RESET_VALUE`.
- First cycle after `areset_n` rises: `awready`, `wready`, `arready` go to 1.
- Write latency: `bvalid` rises 1 cycle after the last of the AW/W handshakes.
- Read latency: `rvalid` rises 1 cycle after the AR handshake.
- Back-to-back throughput with ready held high: one transaction per 2 cycles per channel.
- Read and write to the same register completing on the same edge: the read returns the pre-write value.
- `areset_n` asserted mid-transaction: both FSMs return to idle and registers reload immediately. The pending response is lost and no partial write is committed.

## Configuration
- `AXI_LITE_REGFILE_SLVERR_EN`
  - Defined: out-of-range accesses respond SLVERR (2'b10).
  - Undefined: out-of-range accesses respond OKAY (2'b00). Data behaviour (writes dropped, reads return 0) is identical either way.

## Structure
- `axi_lite_pkg` holds the shared definitions:
  - `ADDR_WIDTH`=32, `DATA_WIDTH`=32, `STRB_WIDTH`=4
  - `addr_t`, `data_t`, `strb_t`
  - `resp_t` enum: OKAY=2'b00, SLVERR=2'b10
- One sub-module, `axi_lite_regfile_decode`: combinational; takes `addr` and outputs `index` and `in_range`. It is instantiated twice, once for write and once for read.

## Test plan
- Write 32'hDEAD_BEEF to `BASE_ADDR`+8 with AW and W in the same cycle and `wstrb`=4'hF → `bvalid` 1 cycle later with OKAY; a read of `BASE_ADDR`+8 returns 32'hDEAD_BEEF with OKAY.
- Present W three cycles before AW → `wready` drops after the W handshake, `bvalid` rises 1 cycle after AW, and the register is updated.
- Register holds 32'h1111_1111; write 32'hAABB_CCDD with `wstrb`=4'b0101 → a read returns 32'h11BB_11DD.
- Read `BASE_ADDR`+64 with `NUM_REGS`=16 → `rdata`=0; `rresp`=SLVERR when the macro is defined, OKAY when it is not. A write to the same address leaves all registers unchanged.
- Hold `bready`=0 for 5 cycles → `bvalid`/`bresp` stay stable and `awready`=`wready`=0 throughout. Meanwhile a read completes normally.
- Assert `areset_n`=0 while in W_HAVE_ADDR → all outputs return to their reset values asynchronously and the register contents equal `RESET_VALUE`.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite widths, types and response codes for the
// register-bank slave. Optional feature macro: AXI_LITE_REGFILE_SLVERR_EN
// (defined: out-of-range accesses answer SLVERR; undefined: they answer OKAY).
package axi_lite_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_e;

  // Response for an access that misses the register window.
`ifdef AXI_LITE_REGFILE_SLVERR_EN
  localparam resp_t OOR_RESP = SLVERR;
`else
  localparam resp_t OOR_RESP = OKAY;
`endif

  // Byte-lane merge: lane i takes the new byte only when its strobe is set.
  function automatic data_t apply_strb(input data_t old_v, input data_t new_v,
                                       input strb_t strb);
    data_t r;
    r = old_v;
    for (int i = 0; i < STRB_WIDTH; i++)
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_decode.sv
// axi_lite_regfile_decode: combinational address decode for the register bank.
// Ports:
//   addr     in  byte address from AW or AR channel
//   index    out register index (offset[9:2]); meaningful only when in_range
//   in_range out address falls inside [BASE_ADDR, BASE_ADDR + NUM_REGS*4)
module axi_lite_regfile_decode
  import axi_lite_pkg::*;
#(
  parameter addr_t BASE_ADDR = 32'h0000_0000,
  parameter int    NUM_REGS  = 16
) (
  input  addr_t      addr,
  output logic [7:0] index,
  output logic       in_range
);

  localparam addr_t LIMIT = addr_t'(NUM_REGS * 4);

  addr_t offset;

  // Subtraction wraps for addr < BASE_ADDR, hence the explicit lower-bound test.
  assign offset   = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && (offset < LIMIT);
  assign index    = offset[9:2];

endmodule

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave holding NUM_REGS 32-bit registers with
// byte-strobe writes. Independent write and read FSMs, one transaction
// outstanding per channel.
// Ports:
//   aclk, areset_n                    clock, async active-low reset
//   awaddr/awvalid/awready            write address channel
//   wdata/wstrb/wvalid/wready         write data channel
//   bresp/bvalid/bready               write response channel
//   araddr/arvalid/arready            read address channel
//   rdata/rresp/rvalid/rready         read data channel
// Optional feature macro: AXI_LITE_REGFILE_SLVERR_EN (see axi_lite_pkg).
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter addr_t BASE_ADDR   = 32'h0000_0000,
  parameter int    NUM_REGS    = 16,
  parameter data_t RESET_VALUE = 32'h0
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  addr_t       awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  data_t       wdata,
  input  strb_t       wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  addr_t       araddr,
  input  logic        arvalid,
  output logic        arready,
  output data_t       rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  // init_q keeps all readies low while in reset and for the reset-release cycle.
  logic       init_q, init_d;
  wstate_e    wst_q, wst_d;
  rstate_e    rst_q, rst_d;
  logic [7:0] aw_idx_q, aw_idx_d;
  logic       aw_ok_q, aw_ok_d;
  data_t      wdata_q, wdata_d;
  strb_t      wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d;
  data_t      rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  data_t      regs_q [NUM_REGS];
  data_t      regs_d [NUM_REGS];

  logic [7:0] wdec_idx, rdec_idx;
  logic       wdec_ok, rdec_ok;

  axi_lite_regfile_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_wdec (
    .addr(awaddr), .index(wdec_idx), .in_range(wdec_ok)
  );

  axi_lite_regfile_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_rdec (
    .addr(araddr), .index(rdec_idx), .in_range(rdec_ok)
  );

  assign awready = init_q && (wst_q == W_IDLE || wst_q == W_HAVE_DATA);
  assign wready  = init_q && (wst_q == W_IDLE || wst_q == W_HAVE_ADDR);
  assign arready = init_q && (rst_q == R_IDLE);
  assign bvalid  = (wst_q == W_RESP);
  assign rvalid  = (rst_q == R_RESP);
  assign bresp   = bresp_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  logic       aw_hs, w_hs, ar_hs, commit;
  logic [7:0] c_idx;
  logic       c_ok;
  data_t      c_data;
  strb_t      c_strb;
  data_t      rd_val;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A handshake in the commit cycle supplies its fields directly; otherwise
  // they come from the half captured earlier.
  assign c_idx  = aw_hs ? wdec_idx : aw_idx_q;
  assign c_ok   = aw_hs ? wdec_ok  : aw_ok_q;
  assign c_data = w_hs  ? wdata    : wdata_q;
  assign c_strb = w_hs  ? wstrb    : wstrb_q;

  // Write channel
  always_comb begin
    init_d   = 1'b1;
    wst_d    = wst_q;
    aw_idx_d = aw_idx_q;
    aw_ok_d  = aw_ok_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    commit   = 1'b0;

    if (aw_hs) begin
      aw_idx_d = wdec_idx;
      aw_ok_d  = wdec_ok;
    end
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end

    case (wst_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          wst_d  = W_RESP;
        end else if (aw_hs) begin
          wst_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wst_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        commit = 1'b1;
        wst_d  = W_RESP;
      end
      W_HAVE_DATA: if (aw_hs) begin
        commit = 1'b1;
        wst_d  = W_RESP;
      end
      W_RESP: if (bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase

    if (commit) begin
      bresp_d = c_ok ? OKAY : OOR_RESP;
      for (int i = 0; i < NUM_REGS; i++)
        if (c_ok && c_idx == 8'(i)) regs_d[i] = apply_strb(regs_q[i], c_data, c_strb);
    end
  end

  // Read channel: rd_val samples the pre-update contents, so a read and a
  // write landing on the same edge returns the old value.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rdec_idx == 8'(i)) rd_val = regs_q[i];
  end

  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (rst_q)
      R_IDLE: if (ar_hs) begin
        rdata_d = rdec_ok ? rd_val : '0;
        rresp_d = rdec_ok ? OKAY : OOR_RESP;
        rst_d   = R_RESP;
      end
      R_RESP: if (rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      init_q   <= 1'b0;
      wst_q    <= W_IDLE;
      rst_q    <= R_IDLE;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      init_q   <= init_d;
      wst_q    <= wst_d;
      rst_q    <= rst_d;
      aw_idx_q <= aw_idx_d;
      aw_ok_q  <= aw_ok_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: table-driven vectors with response scoreboards plus
// hand-written sequences for split handshakes, backpressure, same-edge
// read/write and mid-transaction reset.
module tb_axi_lite_regfile;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] RV   = 32'hA5A5_5A5A;
  localparam logic [1:0]  OK   = 2'b00;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
  localparam logic [1:0]  OOR  = 2'b10;
`else
  localparam logic [1:0]  OOR  = 2'b00;
`endif

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .RESET_VALUE(RV)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // AW and W presented together; checks 1-cycle response latency.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int n = 0;
    bq.push_back(er);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      tick(); n++;
      if (aw_now) begin aw_done = 1; awvalid = 0; end
      if (w_now)  begin w_done = 1;  wvalid = 0;  end
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", 64'(aw_done && w_done), 64'd1);
    chk("wr_bvalid_lat", 64'(bvalid), 64'd1);
    chk("wr_bresp", 64'(bresp), 64'(bq.pop_front()));
    tick();
    chk("wr_bvalid_drop", 64'(bvalid), 64'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit done = 0, now;
    int n = 0;
    logic [33:0] e;
    rq.push_back({ed, er});
    araddr = a; arvalid = 1;
    while (!done && n < 20) begin
      now = arvalid && arready;
      tick(); n++;
      if (now) begin done = 1; arvalid = 0; end
    end
    arvalid = 0;
    chk("rd_handshake", 64'(done), 64'd1);
    chk("rd_rvalid_lat", 64'(rvalid), 64'd1);
    e = rq.pop_front();
    chk("rd_rdata", 64'(rdata), 64'(e[33:2]));
    chk("rd_rresp", 64'(rresp), 64'(e[1:0]));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    araddr = 0; arvalid = 0; bready = 1; rready = 1;

    // Reset state
    repeat (3) tick();
    chk("rst_outs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    areset_n = 1;
    #2;
    chk("rst_rel_readies_low", 64'({awready, wready, arready}), 64'd0);
    tick();
    chk("rst_rel_readies_high", 64'({awready, wready, arready}), 64'b111);

    // Table: wr entries compare bresp; rd entries compare rdata (data) and rresp.
    tbl[0]  = '{1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 4'hF, OK};
    tbl[1]  = '{1'b0, BASE + 32'h08, 32'hDEAD_BEEF, 4'h0, OK};
    tbl[2]  = '{1'b1, BASE + 32'h00, 32'h1111_1111, 4'hF, OK};
    tbl[3]  = '{1'b1, BASE + 32'h00, 32'hAABB_CCDD, 4'b0101, OK};
    tbl[4]  = '{1'b0, BASE + 32'h00, 32'h11BB_11DD, 4'h0, OK};
    tbl[5]  = '{1'b1, BASE + 32'h04, 32'h1234_5678, 4'hF, OK};
    tbl[6]  = '{1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'h0, OK};
    tbl[7]  = '{1'b0, BASE + 32'h07, 32'h1234_5678, 4'h0, OK};
    tbl[8]  = '{1'b1, BASE + 32'h3C, 32'hCAFE_F00D, 4'hF, OK};
    tbl[9]  = '{1'b0, BASE + 32'h3F, 32'hCAFE_F00D, 4'h0, OK};
    tbl[10] = '{1'b1, BASE + 32'h40, 32'h5555_5555, 4'hF, OOR};
    tbl[11] = '{1'b0, BASE + 32'h40, 32'h0000_0000, 4'h0, OOR};
    tbl[12] = '{1'b1, BASE - 32'h04, 32'h6666_6666, 4'hF, OOR};
    tbl[13] = '{1'b0, BASE - 32'h04, 32'h0000_0000, 4'h0, OOR};
    tbl[14] = '{1'b0, BASE + 32'h10, RV,            4'h0, OK};
    tbl[15] = '{1'b0, BASE + 32'h3C, 32'hCAFE_F00D, 4'h0, OK};

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp);
      else           rd(tbl[i].addr, tbl[i].data, tbl[i].resp);
    end
    // Out-of-range writes must not have aliased onto any register.
    rd(BASE + 32'h08, 32'hDEAD_BEEF, OK);
    rd(BASE + 32'h00, 32'h11BB_11DD, OK);
    rd(BASE + 32'h04, 32'h1234_5678, OK);

    // W three cycles ahead of AW
    wvalid = 1; wdata = 32'h2468_ACE0; wstrb = 4'hF;
    tick();
    wvalid = 0;
    chk("wfirst_wready_low", 64'(wready), 64'd0);
    chk("wfirst_awready_high", 64'(awready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wfirst_no_bvalid", 64'(bvalid), 64'd0);
    end
    awaddr = BASE + 32'h18; awvalid = 1;
    tick();
    awvalid = 0;
    chk("wfirst_bvalid", 64'(bvalid), 64'd1);
    chk("wfirst_bresp", 64'(bresp), 64'(OK));
    tick();
    rd(BASE + 32'h18, 32'h2468_ACE0, OK);

    // bready held low: response stable, readies low, reads still serviced
    bready = 0;
    awaddr = BASE + 32'h14; awvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      chk("hold_bresp", 64'(bresp), 64'(OK));
      chk("hold_readies", 64'({awready, wready}), 64'd0);
      if (i == 2) rd(BASE + 32'h14, 32'h0BAD_F00D, OK);
      else tick();
    end
    bready = 1;
    tick();
    chk("hold_release", 64'(bvalid), 64'd0);

    // Same-edge read and write of one register: read sees old value
    awaddr = BASE + 32'h08; awvalid = 1; wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1;
    araddr = BASE + 32'h08; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_edge_valids", 64'({bvalid, rvalid}), 64'b11);
    chk("same_edge_rdata", 64'(rdata), 64'hDEAD_BEEF);
    tick();
    rd(BASE + 32'h08, 32'h7777_8888, OK);

    // Reset while in W_HAVE_ADDR
    awaddr = BASE + 32'h0C; awvalid = 1;
    tick();
    awvalid = 0;
    chk("mid_have_addr", 64'({awready, wready}), 64'b01);
    #2;
    areset_n = 0;
    #1;
    chk("mid_rst_outs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    tick();
    areset_n = 1;
    tick();
    chk("mid_rst_no_resp", 64'(bvalid), 64'd0);
    rd(BASE + 32'h08, RV, OK);
    rd(BASE + 32'h18, RV, OK);
    rd(BASE + 32'h0C, RV, OK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
